// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and the MEM stage.
// One transaction in flight; starvation guard for fetch and a bus timeout watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_valid,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                timeout_err
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                owner_mem_r;
  logic [3:0]          starve_r;
  logic [9:0]          tmo_r;
  logic                bus_req_r;
  logic                bus_we_r;
  logic [ADDR_W-1:0]   bus_addr_r;
  logic [DATA_W-1:0]   bus_wdata_r;
  logic [BE_W-1:0]     bus_be_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic [DATA_W-1:0]   mem_rdata_r;
  logic                if_valid_r;
  logic                mem_valid_r;
  logic                timeout_err_r;
  logic                grant_mem_s;
  logic                abort_s;
  logic [DATA_W-1:0]   resp_data_s;

  // Next-state, arbitration winner and completion data selection.
  always_comb begin
    next_state_s = state_r;
    grant_mem_s  = 1'b0;
    abort_s      = 1'b0;
    resp_data_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (mem_req && !(if_req && (starve_r == STARVE_MAX))) begin
          grant_mem_s = 1'b1;
        end else begin
          grant_mem_s = 1'b0;
        end
        if (if_req || mem_req) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (tmo_r == TMO_LAST) begin
          abort_s      = 1'b1;
          next_state_s = ST_RESP;
        end else if (bus_gnt) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A response arriving on the timeout cycle still counts as a normal completion.
        if (bus_rvalid) begin
          next_state_s = ST_RESP;
          if (bus_we_r) begin
            resp_data_s = '0;
          end else begin
            resp_data_s = bus_rdata;
          end
        end else if (tmo_r == TMO_LAST) begin
          abort_s      = 1'b1;
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
    if (abort_s && !owner_mem_r) begin
      resp_data_s = NOP_WORD;
    end else begin
      resp_data_s = resp_data_s;
    end
  end

  // State, latched payload, counters and registered completion outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      owner_mem_r   <= 1'b0;
      starve_r      <= 4'd0;
      tmo_r         <= 10'd0;
      bus_req_r     <= 1'b0;
      bus_we_r      <= 1'b0;
      bus_addr_r    <= '0;
      bus_wdata_r   <= '0;
      bus_be_r      <= '0;
      if_rdata_r    <= '0;
      mem_rdata_r   <= '0;
      if_valid_r    <= 1'b0;
      mem_valid_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      bus_req_r   <= (next_state_s == ST_ISSUE);
      if_valid_r  <= 1'b0;
      mem_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tmo_r <= 10'd0;
          if (if_req || mem_req) begin
            owner_mem_r <= grant_mem_s;
            if (grant_mem_s) begin
              bus_we_r    <= mem_we;
              bus_addr_r  <= mem_addr;
              bus_wdata_r <= mem_wdata;
              bus_be_r    <= mem_be;
            end else begin
              bus_we_r    <= 1'b0;
              bus_addr_r  <= if_addr;
              bus_wdata_r <= '0;
              bus_be_r    <= '1;
            end
          end
          // A MEM win only counts against fetch when fetch is actually waiting.
          if (!if_req || !grant_mem_s) begin
            starve_r <= 4'd0;
          end else if (starve_r != 4'hF) begin
            starve_r <= starve_r + 4'd1;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          tmo_r <= tmo_r + 10'd1;
          if (next_state_s == ST_RESP) begin
            if (owner_mem_r) begin
              mem_valid_r <= 1'b1;
              mem_rdata_r <= resp_data_s;
            end else begin
              if_valid_r <= 1'b1;
              if_rdata_r <= resp_data_s;
            end
          end
          if (abort_s) begin
            timeout_err_r <= 1'b1;
          end
        end
        ST_RESP: begin
          tmo_r <= tmo_r;
        end
        default: begin
          tmo_r <= 10'd0;
        end
      endcase
    end
  end

  assign bus_req     = bus_req_r;
  assign bus_we      = bus_we_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wdata   = bus_wdata_r;
  assign bus_be      = bus_be_r;
  assign if_rdata    = if_rdata_r;
  assign if_valid    = if_valid_r;
  assign mem_rdata   = mem_rdata_r;
  assign mem_valid   = mem_valid_r;
  assign timeout_err = timeout_err_r;
  assign stall_if    = if_req & ~if_valid_r;
  assign stall_mem   = mem_req & ~mem_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a bus responder and a rule-level arbitration model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int SL = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  logic if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic if_valid;
  logic mem_req;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic mem_valid;
  logic bus_req;
  logic bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [BW-1:0] bus_be;
  logic bus_gnt;
  logic bus_rvalid;
  logic [DW-1:0] bus_rdata;
  logic stall_if;
  logic stall_mem;
  logic timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Responder controls: 0 off, 1 fixed delays, 2 stale rvalid every cycle, 3 random delays.
  int rsp_mode = 0;
  int gnt_dly = 0;
  int rv_dly = 0;
  logic          seen_we;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_wdata;
  logic [BW-1:0] seen_be;
  int gnt_cyc = 0;
  int rv_cyc = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by reads: one fixed instruction word, a hash elsewhere.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  initial begin
    int phase;
    int cnt;
    int gd;
    int rd;
    phase = 0; cnt = 0; gd = 0; rd = 0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      if (rsp_mode == 0) begin
        phase = 0; cnt = 0;
      end else if (rsp_mode == 2) begin
        phase = 0; cnt = 0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
      end else if (phase == 0) begin
        if (bus_req) begin
          if (cnt == 0) gd = (rsp_mode == 3) ? int'($urandom_range(0, 2)) : gnt_dly;
          if (cnt >= gd) begin
            bus_gnt = 1'b1;
            seen_we = bus_we; seen_addr = bus_addr; seen_wdata = bus_wdata; seen_be = bus_be;
            gnt_cyc = cyc;
            phase = 1; cnt = 0;
            rd = (rsp_mode == 3) ? int'($urandom_range(0, 2)) : rv_dly;
          end else begin
            cnt++;
          end
        end
      end else begin
        if (cnt >= rd) begin
          bus_rvalid = 1'b1;
          bus_rdata = seen_we ? 32'hFFFF_FFFF : rd_val(seen_addr);
          rv_cyc = cyc;
          phase = 0; cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_valid || mem_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be} !== '0) begin
      failures++; $display("FAIL reset_bus: got %0h expected 0", {bus_req, bus_we, bus_addr, bus_wdata, bus_be});
    end
    checks++;
    if ({if_rdata, mem_rdata, if_valid, mem_valid, timeout_err} !== '0) begin
      failures++; $display("FAIL reset_resp: got %0h expected 0", {if_rdata, mem_rdata, if_valid, mem_valid, timeout_err});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    rsp_mode = 1; gnt_dly = 0; rv_dly = 0;
    if_addr = 32'h0000_0100; if_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_be, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h0000_0100}) begin
      failures++; $display("FAIL fetch_issue: got %0h expected %0h", {bus_req, bus_we, bus_be, bus_addr}, {1'b1, 1'b0, 4'hF, 32'h0000_0100});
    end
    @(negedge clk);
    checks++;
    if ({bus_req, if_valid, stall_if} !== 3'b001) begin
      failures++; $display("FAIL fetch_wait: got %b expected 001", {bus_req, if_valid, stall_if});
    end
    @(negedge clk);
    checks++;
    if ({if_valid, mem_valid, stall_if} !== 3'b100) begin
      failures++; $display("FAIL fetch_valid_cycle3: got %b expected 100", {if_valid, mem_valid, stall_if});
    end
    checks++;
    if (if_rdata !== 32'h0050_0093) begin
      failures++; $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0 || if_rdata !== 32'h0050_0093) begin
      failures++; $display("FAIL fetch_pulse_hold: got valid=%b rdata=%h expected 0/00500093", if_valid, if_rdata);
    end
  endtask

  task automatic test_store();
    int n_issue;
    bit stable_ok;
    bit stall_ok;
    bit got;
    int vcyc;
    n_issue = 0; stable_ok = 1'b1; stall_ok = 1'b1; got = 1'b0; vcyc = 0;
    rsp_mode = 1; gnt_dly = 3; rv_dly = 1;
    mem_we = 1'b1; mem_addr = 32'h0000_2000; mem_wdata = 32'hDEAD_BEEF; mem_be = 4'b0011; mem_req = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (bus_req) begin
        n_issue++;
        if ({bus_we, bus_addr, bus_wdata, bus_be} !== {1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011}) stable_ok = 1'b0;
      end
      if (mem_valid) begin
        got = 1'b1; vcyc = cyc;
      end else if (stall_mem !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL store_valid: got none expected mem_valid"); end
    checks++;
    if (n_issue != 4 || !stable_ok) begin
      failures++; $display("FAIL store_issue: got cycles=%0d stable=%0d expected 4/1", n_issue, stable_ok);
    end
    checks++;
    if (!stall_ok) begin failures++; $display("FAIL store_stall: got stall_mem low expected high before valid"); end
    checks++;
    if (vcyc != rv_cyc + 1) begin failures++; $display("FAIL store_latency: got %0d expected %0d", vcyc, rv_cyc + 1); end
    checks++;
    if ({mem_rdata, if_valid, stall_mem} !== {32'h0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL store_rdata: got %h/%b/%b expected 0/0/0", mem_rdata, if_valid, stall_mem);
    end
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0) begin failures++; $display("FAIL store_pulse: got %b expected 0", mem_valid); end
  endtask

  task automatic test_contention();
    bit exp_if[10];
    int cnt;
    bit ok;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      exp_if[k] = (cnt == SL);
      cnt = exp_if[k] ? 0 : cnt + 1;
    end
    rsp_mode = 3;
    if_addr = 32'h0000_0400; if_req = 1'b1;
    mem_we = 1'b0; mem_addr = 32'h0000_3000; mem_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_valid(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL contention_timeout: got no valid expected one at %0d", k); break; end
      checks++;
      if ({if_valid, mem_valid} !== {exp_if[k], ~exp_if[k]}) begin
        failures++; $display("FAIL contention_order: got if=%b mem=%b expected if=%b at %0d", if_valid, mem_valid, exp_if[k], k);
      end
      checks++;
      if (if_valid ? (if_rdata !== rd_val(if_addr)) : (mem_rdata !== rd_val(mem_addr))) begin
        failures++; $display("FAIL contention_data: got %h/%h at %0d", if_rdata, mem_rdata, k);
      end
      if (if_valid) if_addr = if_addr + 32'd4;
      else mem_addr = mem_addr + 32'd4;
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int starve;
    int pick;
    bit pend_if;
    bit pend_mem;
    bit ok;
    bit exp_mem;
    logic [31:0] exp_data;
    starve = 0;
    rsp_mode = 3;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      pick = int'($urandom_range(1, 3));
      pend_if = pick[0]; pend_mem = pick[1];
      if_addr = $urandom & 32'hFFFF_FFFC;
      mem_we = 1'($urandom_range(0, 1));
      mem_addr = $urandom & 32'hFFFF_FFFC;
      mem_wdata = $urandom;
      mem_be = 4'($urandom_range(1, 15));
      if_req = pend_if; mem_req = pend_mem;
      while (pend_if || pend_mem) begin
        exp_mem = (pend_if && pend_mem) ? (starve != SL) : pend_mem;
        wait_valid(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL random_timeout: got no valid at iteration %0d", it); break; end
        checks++;
        if ({if_valid, mem_valid} !== {~exp_mem, exp_mem}) begin
          failures++; $display("FAIL random_winner: got if=%b mem=%b expected mem=%b it=%0d", if_valid, mem_valid, exp_mem, it);
        end
        if (exp_mem) begin
          exp_data = mem_we ? 32'h0 : rd_val(mem_addr);
          checks++;
          if ({seen_we, seen_addr, seen_be} !== {mem_we, mem_addr, mem_be} || (mem_we && seen_wdata !== mem_wdata) || mem_rdata !== exp_data) begin
            failures++; $display("FAIL random_mem: got addr=%h be=%h rdata=%h expected addr=%h be=%h rdata=%h", seen_addr, seen_be, mem_rdata, mem_addr, mem_be, exp_data);
          end
          starve = pend_if ? ((starve == 15) ? 15 : starve + 1) : 0;
          pend_mem = 1'b0; mem_req = 1'b0;
        end else begin
          exp_data = rd_val(if_addr);
          checks++;
          if ({seen_we, seen_addr, seen_be} !== {1'b0, if_addr, 4'hF} || if_rdata !== exp_data) begin
            failures++; $display("FAIL random_if: got addr=%h rdata=%h expected addr=%h rdata=%h", seen_addr, if_rdata, if_addr, exp_data);
          end
          starve = 0;
          pend_if = 1'b0; if_req = 1'b0;
        end
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_coincide();
    bit ok;
    rsp_mode = 1; gnt_dly = 0; rv_dly = TO - 2;
    if_addr = 32'h0000_0500; if_req = 1'b1;
    wait_valid(ok);
    checks++;
    if (!ok || if_valid !== 1'b1 || if_rdata !== rd_val(32'h0000_0500)) begin
      failures++; $display("FAIL coincide_data: got ok=%0d valid=%b rdata=%h expected %h", ok, if_valid, if_rdata, rd_val(32'h0000_0500));
    end
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL coincide_err: got %b expected 0", timeout_err); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int hi;
    bit seen_hi;
    bit done;
    bit ok;
    hi = 0; seen_hi = 1'b0; done = 1'b0;
    rsp_mode = 0;
    if_addr = 32'h0000_0600; if_req = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus_req) begin hi++; seen_hi = 1'b1; end
      else if (seen_hi) done = 1'b1;
    end
    checks++;
    if (!done || hi != TO) begin failures++; $display("FAIL timeout_req_len: got %0d expected %0d", hi, TO); end
    checks++;
    if ({if_valid, mem_valid, if_rdata, timeout_err} !== {1'b1, 1'b0, 32'h0000_0013, 1'b1}) begin
      failures++; $display("FAIL timeout_abort: got valid=%b rdata=%h err=%b expected 1/00000013/1", if_valid, if_rdata, timeout_err);
    end
    if_req = 1'b0;
    rsp_mode = 1; gnt_dly = 0; rv_dly = 0;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 32'h0000_0700; mem_req = 1'b1;
    wait_valid(ok);
    checks++;
    if (!ok || mem_rdata !== rd_val(32'h0000_0700) || timeout_err !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky: got rdata=%h err=%b expected %h/1", mem_rdata, timeout_err, rd_val(32'h0000_0700));
    end
    mem_req = 1'b0;
    rsp_mode = 0;
    @(negedge clk);
    mem_addr = 32'h0000_0704; mem_req = 1'b1;
    wait_valid(ok);
    checks++;
    if (!ok || mem_valid !== 1'b1 || mem_rdata !== 32'h0) begin
      failures++; $display("FAIL timeout_mem: got valid=%b rdata=%h expected 1/0", mem_valid, mem_rdata);
    end
    mem_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    bit seen_hi;
    bit in_wait;
    bit quiet;
    seen_hi = 1'b0; in_wait = 1'b0; quiet = 1'b1;
    rsp_mode = 1; gnt_dly = 0; rv_dly = 20;
    if_addr = 32'h0000_0800; if_req = 1'b1;
    for (int i = 0; i < 20 && !in_wait; i++) begin
      @(negedge clk);
      if (bus_req) seen_hi = 1'b1;
      else if (seen_hi) in_wait = 1'b1;
    end
    checks++;
    if (!in_wait) begin failures++; $display("FAIL midwait_reach: got no WAIT expected WAIT"); end
    rsp_mode = 0; reset = 1'b0; if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be, if_rdata, mem_rdata, if_valid, mem_valid, timeout_err} !== '0) begin
      failures++; $display("FAIL midwait_reset: got nonzero outputs expected all 0 (if_rdata=%h err=%b)", if_rdata, timeout_err);
    end
    reset = 1'b1; rsp_mode = 2;
    repeat (2) @(negedge clk);
    rsp_mode = 0;
    for (int i = 0; i < 4; i++) begin
      if (if_valid || mem_valid || bus_req) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!quiet) begin failures++; $display("FAIL midwait_stale: got valid or bus_req expected none"); end
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_random();
    test_coincide();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
